// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver.
// Holds the FSM encoding, data width and bit-period derivation.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int MIN_CLKS_PER_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    // Clock cycles per serial bit, truncated, never below the
    // minimum needed for a meaningful mid-bit sample point.
    function automatic int clks_per_bit(
        input int clk_hz,
        input int baud
    );
        int c;
        c = clk_hz / baud;
        return (c < MIN_CLKS_PER_BIT) ? MIN_CLKS_PER_BIT : c;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: small synchronous FIFO for received bytes.
// Ports: clk, rst_n (async, active-low), push/din, pop, full,
// empty, head (combinational read of oldest entry, 0 when empty).
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells a full ring from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on the same edge frees the slot a full push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with byte FIFO and sticky error flags.
// Ports: CLK, RESET (async, active-low), RXD serial in, RD pop
// strobe, DATA/VALID FIFO head, FRAME_ERR/OVERRUN sticky flags,
// ERR_CLR one-cycle flag clear.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RXD,
    input  logic                 RD,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN,
    input  logic                 ERR_CLR
);

    localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW  = $clog2(CPB + 1);
    localparam int BW  = $clog2(DATA_BITS);

    // The counter expires on the cycle it reads zero, so loads
    // are one less than the wanted interval.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CPB - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 armed;
    logic                 tick;
    logic                 stop_ok;
    logic                 stop_bad;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 overflow;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rx_s    <= rx_meta;
        end
    end

    assign tick     = (baud_cnt == '0);
    assign stop_ok  = (state == ST_STOP) && tick && rx_s;
    assign stop_bad = (state == ST_STOP) && tick && !rx_s;

    // A pop on the same edge makes room, so only RD-less
    // pushes into a full FIFO are lost.
    assign overflow = stop_ok && fifo_full && !RD;

    // armed: line has been seen high since reset or since a
    // low stop bit, so a held-low break cannot restart a frame.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            armed     <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state    <= ST_START;
                        bit_cnt  <= '0;
                        baud_cnt <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state    <= ST_DATA;
                            baud_cnt <= FULL_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        baud_cnt <= FULL_LOAD;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        if (!rx_s) begin
                            armed <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A new error event outranks a coincident clear.
            if (stop_bad) begin
                FRAME_ERR <= 1'b1;
            end else if (ERR_CLR) begin
                FRAME_ERR <= 1'b0;
            end

            if (overflow) begin
                OVERRUN <= 1'b1;
            end else if (ERR_CLR) begin
                OVERRUN <= 1'b0;
            end
        end
    end

    rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (stop_ok),
        .din   (shreg),
        .pop   (RD),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (DATA)
    );

    assign VALID = !fifo_empty;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE, integer-truncated, minimum 4.
REQ-003 Parameter FIFO_DEPTH, default 4, received-byte buffer depth; power of two, 2..16.
REQ-004 CLK  input  1  single system clock, all state on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset; 0 = reset.
REQ-006 RXD  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 RD  input  1  read strobe; pops one byte when VALID=1.
REQ-008 DATA  output  8  byte at FIFO head; stable while VALID=1 and RD=0.
REQ-009 VALID  output  1  FIFO non-empty.
REQ-010 FRAME_ERR  output  1  sticky; stop bit sampled low.
REQ-011 OVERRUN  output  1  sticky; byte completed while FIFO full.
REQ-012 ERR_CLR  input  1  one-cycle pulse; clears FRAME_ERR and OVERRUN.

Function
REQ-013 RXD SHALL pass through a 2-flop synchronizer preset to 1; all decisions use the synchronized value.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: synchronized RXD=0 -> START, bit counter cleared, baud counter loaded with CLKS_PER_BIT/2.
REQ-016 START: at baud counter expiry, sample RXD; 0 -> DATA with baud counter = CLKS_PER_BIT; 1 -> IDLE (glitch rejected, no error).
REQ-017 DATA: sample RXD at each expiry, shift into bit (bit index) LSB first; after 8th sample -> STOP.
REQ-018 STOP: sample at expiry; 1 -> push byte; 0 -> set FRAME_ERR, discard byte; both -> IDLE the same cycle.
REQ-019 A STOP exit with RXD=0 SHALL NOT re-enter START until RXD has been seen high at least once (break handling).
REQ-020 Push with FIFO full SHALL drop the new byte, keep FIFO contents, and set OVERRUN.
REQ-021 RD with VALID=1 SHALL pop on that edge; RD with VALID=0 SHALL be ignored.
REQ-022 Simultaneous push and pop when full SHALL accept both, with no OVERRUN; when empty SHALL leave VALID=1 with the new byte at the head.
REQ-023 DATA SHALL be read combinationally from the FIFO head; VALID SHALL rise the cycle after the STOP sample.
REQ-024 Latency: STOP sample occurs 9.5*CLKS_PER_BIT (+-1) cycles after the synchronized start edge; total from RXD fall is +2 sync cycles.
REQ-025 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2*FIFO_DEPTH; full/empty derived from MSB compare.
REQ-026 ERR_CLR coincident with a new error event: the set wins.

Reset
REQ-027 RESET=0 SHALL asynchronously force: FSM IDLE, synchronizer flops 1, counters 0, FIFO empty, VALID 0, DATA 0x00, FRAME_ERR 0, OVERRUN 0.
REQ-028 Reset mid-frame SHALL abandon the frame; after release, reception resumes only on a fresh falling edge.

Structure
REQ-029 Shared package uart_pkg SHALL hold the state encoding enum, DATA_BITS=8, and the CLKS_PER_BIT derivation function.
REQ-030 The FIFO SHALL be a sub-module named rx_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, head).
REQ-031 Total RTL SHALL be 120-400 lines.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-032 Byte 0x55 sent at nominal rate, then RD pulsed -> VALID=1, DATA=0x55; after RD, VALID=0; FRAME_ERR=0.
REQ-033 RXD low pulse of 5 cycles -> START rejects it, no VALID, no FRAME_ERR.
REQ-034 Bytes 0xA5 with stop bit forced low -> FRAME_ERR=1, VALID=0; after ERR_CLR pulse -> FRAME_ERR=0.
REQ-035 Five bytes 0x01..0x05 with no RD -> OVERRUN=1; reads return 0x01..0x04, then VALID=0.
REQ-036 RESET asserted midway through 0x3C -> all outputs 0 immediately; next byte 0xC3 is received correctly.
REQ-037 Byte 0x81 sent at +3% and -3% baud error -> DATA=0x81, no error flags.
